dmr_add_sequencer: RTL and testbench
====================================

Name: dmr_add_sequencer

Overview:
- Sequencing stage wrapped around a duplicated (DMR) pair of combinational 16-bit carry-look-ahead adders.
- Upstream side: accepts operand transactions over valid/ready and drives registered operands into both adder copies.
- Downstream side: waits a programmable settle time, then compares the two copies' {cout, sum}.
- On a mismatch it re-evaluates up to MAX_RETRY times, then presents a checked result with an error flag; it also keeps a saturating fault counter.

Parameters:
W, 16, operand/sum width; must match the adder copies.
SETTLE_CYCLES, 1, cycles operands are held before comparison; legal values are 1 and above.
MAX_RETRY, 2, re-evaluations allowed after a mismatch; legal values are 0 and above.
FCNT_W, 8, width of the fault counter.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_ci  input  1  carry in
add_a  output  W  registered operand A to both adder copies
add_b  output  W  registered operand B to both adder copies
add_ci  output  1  registered carry in to both adder copies
s0  input  W  sum from adder copy 0
cout0  input  1  carry out from adder copy 0
s1  input  W  sum from adder copy 1
cout1  input  1  carry out from adder copy 1
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  checked sum
out_cout  output  1  checked carry out
out_err  output  1  copies still disagreed after all retries
out_retries  output  clog2(MAX_RETRY+1), minimum 1  retries used for this result
fault_cnt  output  FCNT_W  total mismatches seen; saturating

Behaviour:
- Reset is asynchronous and active-high. The block has one clock, clk.
- While rst is high, or on reset:
  - state is IDLE;
  - add_a, add_b, add_ci, out_sum, out_cout, out_err, out_retries, fault_cnt and out_valid are all 0;
  - in_ready is 0.
- A reset mid-operation abandons the transaction; no output is produced for it.
- States are IDLE, SETTLE, CHECK and DONE.
- IDLE:
  - in_ready = 1. in_ready is 0 in every other state.
  - When in_valid is high, capture in_a/in_b/in_ci into add_a/add_b/add_ci, clear the retry count, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE:
  - add_* are held stable.
  - The settle counter decrements each cycle; at 0, go to CHECK.
- CHECK (one cycle):
  - Compare {cout0,s0} with {cout1,s1} combinationally.
  - Match: register out_sum=s0, out_cout=cout0, out_err=0 and out_retries=retry count, then go to DONE.
  - Mismatch with retry count < MAX_RETRY: increment the retry count, reload the settle counter, and go to SETTLE. Operands are unchanged.
  - Mismatch with retry count == MAX_RETRY: register out_sum=s0, out_cout=cout0, out_err=1 and out_retries=MAX_RETRY, then go to DONE.
  - Every mismatch increments fault_cnt, which saturates at all-ones and is cleared only by reset.
- DONE:
  - out_valid = 1; out_* are held stable while out_ready is low.
  - When out_ready is high, go to IDLE.
  - A new transaction is accepted no earlier than the cycle after the handshake, so there is one bubble per result.
- Latency with no mismatch:
  - Accept at clock edge N; out_valid is high after edge N+SETTLE_CYCLES+1.
  - Each retry adds SETTLE_CYCLES+1 cycles.
- Arithmetic is performed only by the external adders. The block adds no width beyond W+1 and applies no modulo rule; wrap-around is whatever the adders produce in {cout,sum}.
- in_valid, and the in_* values, are ignored outside IDLE.
- s*/cout* are ignored outside CHECK.

Test Plan:
- Basic add, SETTLE_CYCLES=1: in_a=0x0AA8, in_b=0x0400, in_ci=1, both copies correct → out_sum=0x0EA9, out_cout=0, out_err=0, out_retries=0; out_valid 2 edges after accept; fault_cnt=0.
- Wrap-around: in_a=0xFFFF, in_b=0x0001, in_ci=0 → out_sum=0x0000, out_cout=1. Also in_a=1552, in_b=713 → out_sum=0x08D9.
- Transient fault: copy 1 forced to 0x1234 during the first CHECK only → one retry; out_sum correct, out_err=0, out_retries=1, fault_cnt=1; out_valid 4 edges after accept.
- Persistent fault, MAX_RETRY=2: copy 1 sum bit 0 stuck inverted → out_err=1, out_sum=copy 0 value, out_retries=2, fault_cnt=3; with FCNT_W=2, repeated faults saturate fault_cnt at 3.
- Backpressure: out_ready held low for 5 cycles in DONE → out_* stable, in_ready=0, new in_valid not accepted; accepted the cycle after the handshake.
- Reset mid-SETTLE: assert rst asynchronously between edges → all outputs 0 immediately and state IDLE; the next transaction completes normally with the nominal latency.

Source files
------------

// File: rtl/dmr_add_sequencer.sv
// Sequencer around a duplicated (DMR) pair of external combinational adders:
// registers operands, waits a settle time, compares both copies, retries, and reports.
module dmr_add_sequencer #(
    parameter int W             = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2,
    parameter int FCNT_W        = 8,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    // upstream operand transaction
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic              in_ci,
    // shared operand bus to both adder copies
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_ci,
    // adder copy results
    input  logic [W-1:0]      s0,
    input  logic              cout0,
    input  logic [W-1:0]      s1,
    input  logic              cout1,
    // downstream checked result
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_sum,
    output logic              out_cout,
    output logic              out_err,
    output logic [RW-1:0]     out_retries,
    output logic [FCNT_W-1:0] fault_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    state_t      state;
    state_t      state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [RW-1:0] retry_cnt;

    logic mismatch;
    logic load_ops;
    logic settle_load;
    logic retry_clr;
    logic retry_inc;
    logic res_load;
    logic res_err;
    logic fault_inc;

    // Only meaningful during CHECK; the copies are ignored in every other state.
    assign mismatch = ({cout0, s0} != {cout1, s1});

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        load_ops    = 1'b0;
        settle_load = 1'b0;
        retry_clr   = 1'b0;
        retry_inc   = 1'b0;
        res_load    = 1'b0;
        res_err     = 1'b0;
        fault_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    load_ops    = 1'b1;
                    settle_load = 1'b1;
                    retry_clr   = 1'b1;
                    state_nxt   = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!mismatch) begin
                    res_load  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    fault_inc = 1'b1;
                    if (retry_cnt < RETRY_MAX) begin
                        retry_inc   = 1'b1;
                        settle_load = 1'b1;
                        state_nxt   = SETTLE;
                    end else begin
                        res_load  = 1'b1;
                        res_err   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst so ready stays low while reset is held, even though state reads IDLE.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    // NOTE: only control and datapath registers exist here; all are cleared
    // by the asynchronous reset because every one of them is architecturally visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a  <= '0;
            add_b  <= '0;
            add_ci <= 1'b0;
        end else if (load_ops) begin
            add_a  <= in_a;
            add_b  <= in_b;
            add_ci <= in_ci;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (settle_load) begin
            settle_cnt <= SETTLE_INIT;
        end else if ((state == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (retry_clr) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end

    // Result registers load only on leaving CHECK, so they hold through DONE backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum     <= '0;
            out_cout    <= 1'b0;
            out_err     <= 1'b0;
            out_retries <= '0;
        end else if (res_load) begin
            out_sum     <= s0;
            out_cout    <= cout0;
            out_err     <= res_err;
            out_retries <= retry_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt <= '0;
        end else if (fault_inc && (fault_cnt != '1)) begin
            fault_cnt <= fault_cnt + FCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmr_add_sequencer.sv
// Self-checking bench for dmr_add_sequencer: behavioural adder copies with fault
// injection, a transaction-level expectation queue, and per-cycle output comparison.
module tb_dmr_add_sequencer;

    localparam int W   = 16;
    localparam int SC  = 1;
    localparam int MR  = 2;
    localparam int FW  = 2;
    localparam int FMAX = (1 << FW) - 1;

    typedef enum int {F_NONE, F_TRANS, F_STUCK} fault_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           retries;
        int           fcnt;
        int           lat;
        int           acc_cyc;
        bit           seen;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ci = 1'b0;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_ci;
    logic [W-1:0]  s0;
    logic          cout0;
    logic [W-1:0]  s1;
    logic          cout1;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_err;
    logic [1:0]    out_retries;
    logic [FW-1:0] fault_cnt;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     trans_until = -1;
    int     model_fcnt = 0;
    fault_t fmode = F_NONE;
    exp_t   q[$];

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_err;
    logic [1:0]   last_retries;
    logic [FW-1:0] last_fcnt;

    dmr_add_sequencer #(
        .W(W), .SETTLE_CYCLES(SC), .MAX_RETRY(MR), .FCNT_W(FW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .s0(s0), .cout0(cout0), .s1(s1), .cout1(cout1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
        .out_retries(out_retries), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The two external adder copies; copy 1 can be corrupted.
    logic [W:0] good;
    assign good = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_ci);
    always_comb begin
        {cout0, s0} = good;
        {cout1, s1} = good;
        if (fmode == F_STUCK) begin
            s1 = good[W-1:0] ^ 16'h0001;
        end else if ((fmode == F_TRANS) && (cyc <= trans_until)) begin
            s1 = 16'h1234;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expectation queue.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_in_ready", 32'(in_ready), 0);
            check("rst_add_a", 32'(add_a), 0);
            check("rst_out_sum", 32'(out_sum), 0);
            check("rst_fault_cnt", 32'(fault_cnt), 0);
        end else if (q.size() == 0) begin
            check("idle_in_ready", 32'(in_ready), 1);
            check("idle_out_valid", 32'(out_valid), 0);
        end else begin
            check("busy_in_ready", 32'(in_ready), 0);
            check("hold_add_a", 32'(add_a), 32'(q[0].a));
            check("hold_add_b", 32'(add_b), 32'(q[0].b));
            check("hold_add_ci", 32'(add_ci), 32'(q[0].ci));
            if (out_valid) begin
                if (!q[0].seen) begin
                    check("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                    q[0].seen = 1'b1;
                end
                check("out_sum", 32'(out_sum), 32'(q[0].sum));
                check("out_cout", 32'(out_cout), 32'(q[0].cout));
                check("out_err", 32'(out_err), 32'(q[0].err));
                check("out_retries", 32'(out_retries), 32'(q[0].retries));
                check("fault_cnt", 32'(fault_cnt), 32'(q[0].fcnt));
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready && (q.size() > 0)) q.delete(0);
    end

    // Transaction-level model: result, retries, error, latency and fault total.
    function automatic exp_t predict(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci, input fault_t mode, input int acc);
        exp_t e;
        int   mism;
        int   sum17;
        mism = (mode == F_NONE) ? 0 : (mode == F_TRANS) ? 1 : MR + 1;
        sum17 = int'(a) + int'(b) + int'(ci);
        e.a = a;
        e.b = b;
        e.ci = ci;
        e.sum = sum17[W-1:0];
        e.cout = sum17[W];
        e.retries = (mism < MR) ? mism : MR;
        e.err = (mism > MR);
        e.lat = (SC + 1) * (e.retries + 1);
        model_fcnt = (model_fcnt + mism > FMAX) ? FMAX : model_fcnt + mism;
        e.fcnt = model_fcnt;
        e.acc_cyc = acc;
        e.seen = 1'b0;
        return e;
    endfunction

    // Called at posedge+1. hold = cycles out_ready stays low in DONE; junk drives
    // in_valid with new data during that time, which must be ignored.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input fault_t mode, input int hold, input bit junk);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("accept_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_ci = ci;
        fmode = mode;
        trans_until = cyc + 1 + SC;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        in_ci = 1'($urandom);
        q.push_back(predict(a, b, ci, mode, cyc));
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("out_valid_seen", 32'(out_valid), 1);
        last_sum = out_sum;
        last_cout = out_cout;
        last_err = out_err;
        last_retries = out_retries;
        last_fcnt = fault_cnt;
        in_valid = junk;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("ready_after_handshake", 32'(in_ready), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_retries", 32'(out_retries), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(16'h0AA8, 16'h0400, 1'b1, F_NONE, 0, 1'b0);
        check("lit_basic_sum", 32'(last_sum), 32'h0EA9);
        check("lit_basic_cout", 32'(last_cout), 0);
        check("lit_basic_fcnt", 32'(last_fcnt), 0);

        run_txn(16'hFFFF, 16'h0001, 1'b0, F_NONE, 0, 1'b0);
        check("lit_wrap_sum", 32'(last_sum), 32'h0000);
        check("lit_wrap_cout", 32'(last_cout), 1);

        run_txn(16'd1552, 16'd713, 1'b0, F_NONE, 1, 1'b0);
        check("lit_dec_sum", 32'(last_sum), 32'h08D9);

        run_txn(16'h1111, 16'h2222, 1'b0, F_TRANS, 0, 1'b0);
        check("lit_trans_retries", 32'(last_retries), 1);
        check("lit_trans_fcnt", 32'(last_fcnt), 1);

        run_txn(16'h00FF, 16'h0101, 1'b0, F_STUCK, 0, 1'b0);
        check("lit_stuck_err", 32'(last_err), 1);
        check("lit_stuck_sum", 32'(last_sum), 32'h0200);
        check("lit_stuck_retries", 32'(last_retries), 2);
        check("lit_stuck_fcnt", 32'(last_fcnt), 3);

        run_txn(16'h8000, 16'h8000, 1'b1, F_STUCK, 0, 1'b0);
        check("lit_sat_fcnt", 32'(last_fcnt), 3);

        run_txn(16'h7FFF, 16'h0001, 1'b1, F_NONE, 5, 1'b1);
        run_txn(16'hDEAD, 16'h1111, 1'b0, F_NONE, 0, 1'b0);

        // Reset asserted between edges while the transaction is settling.
        in_valid = 1'b1;
        in_a = 16'h4321;
        in_b = 16'h1234;
        in_ci = 1'b1;
        fmode = F_NONE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back(predict(16'h4321, 16'h1234, 1'b1, F_NONE, cyc));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_add_a", 32'(add_a), 0);
        check("async_rst_fault_cnt", 32'(fault_cnt), 0);
        check("async_rst_in_ready", 32'(in_ready), 0);
        q.delete();
        model_fcnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(16'h0F0F, 16'h00F1, 1'b0, F_NONE, 0, 1'b0);
        check("lit_post_rst_sum", 32'(last_sum), 32'h1000);
        check("lit_post_rst_fcnt", 32'(last_fcnt), 0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
